id_hazard_ctrl: RTL and testbench

Central stall/bubble sequencer for the decode stage. It decides each cycle whether fetch/ID hold (WANT_FREEZE) and whether ID injects a NOP into EXE (BUBBLE_EXE). It detects load-use hazards against EXE and sequences syscall / LL/SC drains. It replaces the ad-hoc syscall bubble counter and freeze/inhibit flags inside ID; ID uses the outputs unchanged.

---
 rtl/id_ctrl_pkg.sv | 17 +
 rtl/load_use_detect.sv | 34 +++
 rtl/id_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_id_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ctrl_pkg.sv
// rtl/id_ctrl_pkg.sv - shared types and constants for the decode-stage hazard controller
package id_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        FIRE   = 2'd2,
        RESUME = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int CNT_W     = 3;
    localparam int STAT_LU_W = 32;
    localparam int STAT_SC_W = 16;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector for one issue slot
//
// Ports:
//   valid         in   ID slot holds a valid instruction
//   uses_rs       in   instruction reads rs
//   uses_rt       in   instruction reads rt
//   rs, rt        in   source register fields
//   exe_mem_read  in   instruction in EXE is a load
//   exe_write_reg in   EXE destination register
//   hazard        out  ID must wait one cycle for the load result
module load_use_detect
    import id_ctrl_pkg::*;
(
    input  logic       valid,
    input  logic       uses_rs,
    input  logic       uses_rt,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       exe_mem_read,
    input  logic [4:0] exe_write_reg,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = uses_rs & (rs == exe_write_reg);
    assign rt_match = uses_rt & (rt == exe_write_reg);

    // $zero never carries a real dependency, so a load into it cannot stall.
    assign hazard = valid & exe_mem_read & (exe_write_reg != REG_ZERO)
                  & (rs_match | rt_match);

endmodule

// File: rtl/id_hazard_ctrl.sv
// rtl/id_hazard_ctrl.sv - decode-stage stall/bubble sequencer (load-use, syscall and LL/SC drains)
//
// Optional build macro: HAZARD_COUNTERS_EN adds saturating event counters.
//
// Ports:
//   CLK, RESET        in   clock, synchronous active-high reset
//   STALL_fMEM        in   memory stall, whole pipe holds
//   Instr1_Valid_IN   in   ID holds a valid instruction
//   Uses_Rs_IN/Rt_IN  in   ID instruction reads rs / rt
//   Rs_IN, Rt_IN      in   source register fields
//   Syscall_IN        in   decoder syscall flag (syscall, LL, SC)
//   LLSC_IN           in   instruction is LL/SC (flush only)
//   EXE_MemRead_IN    in   EXE instruction is a load
//   EXE_WriteReg_IN   in   EXE destination register
//   WANT_FREEZE       out  hold fetch PC and ID input
//   BUBBLE_EXE        out  ID sends a NOP to EXE
//   SYS               out  registered one-cycle simulator syscall request
//   Stat_LoadUse      out  load-use interlock count (HAZARD_COUNTERS_EN only)
//   Stat_Syscall      out  syscall accept count (HAZARD_COUNTERS_EN only)
//   Busy              out  sequencer is not in RUN
module id_hazard_ctrl
    import id_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 STALL_fMEM,
    input  logic                 Instr1_Valid_IN,
    input  logic                 Uses_Rs_IN,
    input  logic                 Uses_Rt_IN,
    input  logic [4:0]           Rs_IN,
    input  logic [4:0]           Rt_IN,
    input  logic                 Syscall_IN,
    input  logic                 LLSC_IN,
    input  logic                 EXE_MemRead_IN,
    input  logic [4:0]           EXE_WriteReg_IN,
    output logic                 WANT_FREEZE,
    output logic                 BUBBLE_EXE,
    output logic                 SYS,
`ifdef HAZARD_COUNTERS_EN
    output logic [STAT_LU_W-1:0] Stat_LoadUse,
    output logic [STAT_SC_W-1:0] Stat_Syscall,
`endif
    output logic                 Busy
);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             llsc_q, llsc_n;
    logic             sys_n;
    logic             hazard;

    load_use_detect u_load_use_detect (
        .valid         (Instr1_Valid_IN),
        .uses_rs       (Uses_Rs_IN),
        .uses_rt       (Uses_Rt_IN),
        .rs            (Rs_IN),
        .rt            (Rt_IN),
        .exe_mem_read  (EXE_MemRead_IN),
        .exe_write_reg (EXE_WriteReg_IN),
        .hazard        (hazard)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= RUN;
            cnt    <= '0;
            llsc_q <= 1'b0;
            SYS    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            llsc_q <= llsc_n;
            SYS    <= sys_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        llsc_n      = llsc_q;
        sys_n       = SYS;
        WANT_FREEZE = 1'b0;
        BUBBLE_EXE  = 1'b0;

        if (STALL_fMEM) begin
            // Memory stall dominates: everything holds, no bubble injected.
            WANT_FREEZE = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (hazard) begin
                        // Checked before syscall accept: a syscall reading a
                        // freshly loaded $v0 must wait for the load first.
                        WANT_FREEZE = 1'b1;
                        BUBBLE_EXE  = 1'b1;
                    end else if (Instr1_Valid_IN && Syscall_IN) begin
                        // Syscall itself goes down once to flush MEM; bubbles follow.
                        WANT_FREEZE = 1'b1;
                        state_n     = DRAIN;
                        cnt_n       = CNT_W'(DRAIN_CYCLES - 1);
                        llsc_n      = LLSC_IN;
                    end
                end
                DRAIN: begin
                    WANT_FREEZE = 1'b1;
                    BUBBLE_EXE  = 1'b1;
                    if (cnt != '0) cnt_n = cnt - CNT_W'(1);
                    else           state_n = FIRE;
                end
                FIRE: begin
                    WANT_FREEZE = 1'b1;
                    BUBBLE_EXE  = 1'b1;
                    state_n     = RESUME;
                    sys_n       = ~llsc_q;
                end
                RESUME: begin
                    // Fetch advances past the syscall; the copy still in ID is squashed.
                    BUBBLE_EXE = 1'b1;
                    state_n    = RUN;
                    sys_n      = 1'b0;
                end
                default: state_n = RUN;
            endcase
        end
    end

    assign Busy = (state != RUN);

`ifdef HAZARD_COUNTERS_EN
    logic run_live;
    logic lu_fire;
    logic accept;

    assign run_live = (state == RUN) & ~STALL_fMEM;
    assign lu_fire  = run_live & hazard;
    assign accept   = run_live & ~hazard & Instr1_Valid_IN & Syscall_IN;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            Stat_LoadUse <= '0;
            Stat_Syscall <= '0;
        end else begin
            if (lu_fire && (Stat_LoadUse != '1))
                Stat_LoadUse <= Stat_LoadUse + STAT_LU_W'(1);
            if (accept && (Stat_Syscall != '1))
                Stat_Syscall <= Stat_Syscall + STAT_SC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb/tb_id_hazard_ctrl.sv - directed self-checking bench for id_hazard_ctrl
module tb_id_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       STALL_fMEM;
    logic       Instr1_Valid_IN;
    logic       Uses_Rs_IN;
    logic       Uses_Rt_IN;
    logic [4:0] Rs_IN;
    logic [4:0] Rt_IN;
    logic       Syscall_IN;
    logic       LLSC_IN;
    logic       EXE_MemRead_IN;
    logic [4:0] EXE_WriteReg_IN;
    logic       WANT_FREEZE;
    logic       BUBBLE_EXE;
    logic       SYS;
    logic       Busy;
`ifdef HAZARD_COUNTERS_EN
    logic [31:0] Stat_LoadUse;
    logic [15:0] Stat_Syscall;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    id_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .STALL_fMEM      (STALL_fMEM),
        .Instr1_Valid_IN (Instr1_Valid_IN),
        .Uses_Rs_IN      (Uses_Rs_IN),
        .Uses_Rt_IN      (Uses_Rt_IN),
        .Rs_IN           (Rs_IN),
        .Rt_IN           (Rt_IN),
        .Syscall_IN      (Syscall_IN),
        .LLSC_IN         (LLSC_IN),
        .EXE_MemRead_IN  (EXE_MemRead_IN),
        .EXE_WriteReg_IN (EXE_WriteReg_IN),
        .WANT_FREEZE     (WANT_FREEZE),
        .BUBBLE_EXE      (BUBBLE_EXE),
        .SYS             (SYS),
`ifdef HAZARD_COUNTERS_EN
        .Stat_LoadUse    (Stat_LoadUse),
        .Stat_Syscall    (Stat_Syscall),
`endif
        .Busy            (Busy)
    );

    // Observed outputs packed as {WANT_FREEZE, BUBBLE_EXE, SYS, Busy}.
    logic [3:0] obs;
    assign obs = {WANT_FREEZE, BUBBLE_EXE, SYS, Busy};

    typedef struct packed {
        logic       stall;
        logic       valid;
        logic       urs;
        logic       urt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mr;
        logic [4:0] wr;
        logic [3:0] exp;
    } lu_vec_t;

    task automatic set_idle();
        RESET           = 1'b0;
        STALL_fMEM      = 1'b0;
        Instr1_Valid_IN = 1'b0;
        Uses_Rs_IN      = 1'b0;
        Uses_Rt_IN      = 1'b0;
        Rs_IN           = 5'd0;
        Rt_IN           = 5'd0;
        Syscall_IN      = 1'b0;
        LLSC_IN         = 1'b0;
        EXE_MemRead_IN  = 1'b0;
        EXE_WriteReg_IN = 5'd0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        set_idle();
        n = 0;
        @(negedge CLK);
        while (Busy !== 1'b0 && n < 20) begin
            next_cycle();
            @(negedge CLK);
            n++;
        end
        n_vec++;
        if (Busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: Busy=%b after %0d cycles, required 0", tag, Busy, n);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        set_idle();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        n_vec++;
        if (obs !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 0000", obs);
        end
        next_cycle();
        STALL_fMEM = 1'b1;
        @(negedge CLK);
        n_vec++;
        if (obs !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_stall_freeze: got %b required 1000", obs);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_load_use();
        lu_vec_t v[7];
        //          stall valid urs urt rs     rt     mr wr     exp
        v[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd8,  5'd0,  1'b1, 5'd8, 4'b1100};
        v[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd8,  5'd0,  1'b0, 5'd0, 4'b0000};
        v[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  1'b1, 5'd0, 4'b0000};
        v[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'd9,  5'd8,  1'b1, 5'd8, 4'b0000};
        v[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  5'd8,  1'b1, 5'd8, 4'b1100};
        v[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  5'd8,  1'b1, 5'd8, 4'b0000};
        v[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd8,  5'd0,  1'b1, 5'd8, 4'b1000};
        for (int i = 0; i < 7; i++) begin
            STALL_fMEM      = v[i].stall;
            Instr1_Valid_IN = v[i].valid;
            Uses_Rs_IN      = v[i].urs;
            Uses_Rt_IN      = v[i].urt;
            Rs_IN           = v[i].rs;
            Rt_IN           = v[i].rt;
            EXE_MemRead_IN  = v[i].mr;
            EXE_WriteReg_IN = v[i].wr;
            @(negedge CLK);
            n_vec++;
            if (obs !== v[i].exp) begin
                n_err++;
                $display("FAIL load_use[%0d]: got %b required %b", i, obs, v[i].exp);
            end
            next_cycle();
        end
        set_idle();
    endtask

    task automatic test_syscall(input logic llsc, input logic back_to_back);
        logic [3:0] exp[8];
        exp[0] = 4'b1000;
        exp[1] = 4'b1101;
        exp[2] = 4'b1101;
        exp[3] = 4'b1101;
        exp[4] = 4'b1101;
        exp[5] = llsc ? 4'b0101 : 4'b0111;
        exp[6] = back_to_back ? 4'b1000 : 4'b0000;
        exp[7] = back_to_back ? 4'b1101 : 4'b0000;
        set_idle();
        for (int k = 0; k < 8; k++) begin
            Instr1_Valid_IN = 1'b1;
            Syscall_IN      = (k <= 5) || back_to_back;
            LLSC_IN         = llsc;
            @(negedge CLK);
            n_vec++;
            if (obs !== exp[k]) begin
                n_err++;
                $display("FAIL syscall_llsc%0b_b2b%0b[T+%0d]: got %b required %b",
                         llsc, back_to_back, k, obs, exp[k]);
            end
            next_cycle();
        end
        wait_idle("syscall");
    endtask

    task automatic test_mem_stall();
        logic [3:0] exp[11];
        logic       stl[11];
        exp = '{4'b1000, 4'b1101, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
                4'b1101, 4'b1101, 4'b1101, 4'b0111, 4'b0000};
        stl = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        set_idle();
        for (int k = 0; k < 11; k++) begin
            STALL_fMEM      = stl[k];
            Instr1_Valid_IN = 1'b1;
            Syscall_IN      = (k <= 9);
            @(negedge CLK);
            n_vec++;
            if (obs !== exp[k]) begin
                n_err++;
                $display("FAIL mem_stall[T+%0d]: got %b required %b", k, obs, exp[k]);
            end
            next_cycle();
        end
        wait_idle("mem_stall");
    endtask

    task automatic test_hazard_syscall();
        logic [3:0] exp[3];
        exp = '{4'b1100, 4'b1000, 4'b1101};
        set_idle();
        for (int k = 0; k < 3; k++) begin
            Instr1_Valid_IN = 1'b1;
            Syscall_IN      = 1'b1;
            Uses_Rt_IN      = 1'b1;
            Rt_IN           = 5'd2;
            EXE_WriteReg_IN = 5'd2;
            EXE_MemRead_IN  = (k == 0);
            @(negedge CLK);
            n_vec++;
            if (obs !== exp[k]) begin
                n_err++;
                $display("FAIL hazard_syscall[%0d]: got %b required %b", k, obs, exp[k]);
            end
            next_cycle();
        end
        wait_idle("hazard_syscall");
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp[7];
        exp = '{4'b1000, 4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1000, 4'b1101};
        set_idle();
        for (int k = 0; k < 7; k++) begin
            Instr1_Valid_IN = 1'b1;
            Syscall_IN      = 1'b1;
            RESET           = (k == 4);
            @(negedge CLK);
            n_vec++;
            if (obs !== exp[k]) begin
                n_err++;
                $display("FAIL reset_mid[T+%0d]: got %b required %b", k, obs, exp[k]);
            end
            next_cycle();
        end
        wait_idle("reset_mid");
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_use();
        test_syscall(1'b0, 1'b0);
        test_syscall(1'b1, 1'b0);
        test_syscall(1'b0, 1'b1);
        test_mem_stall();
        test_hazard_syscall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
